// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and datamem: one request at a time,
// byte-to-word address mapping, read-modify-write for sub-word stores, extended loads.
module lsu_ctrl #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned DEPTH   = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          store_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    lane_q;
  logic [15:0]   wdata_q;
  logic          req_err_c;

  assign req_ready = (state == IDLE);

  // Request is rejected before any memory access when it cannot be honoured.
  always_comb begin
    req_err_c = 1'b0;
    if (req_size == SZ_ILL)                                req_err_c = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])                req_err_c = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)     req_err_c = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DEPTH)                  req_err_c = 1'b1;
  end

  // Replace the addressed lanes of the old word with the right-aligned store data.
  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (sz == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // Right-align the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] extract_word(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            uns_q    <= req_unsigned;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= {2'b00, req_addr[31:2]};
            if (req_err_c) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else if (req_store && req_size == SZ_WORD) begin
              state     <= WR;
              mem_en    <= 1'b1;
              mem_rw    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state  <= RD;
              mem_en <= 1'b1;
            end
          end
        end
        RD: begin
          state <= RWAIT;
          cnt   <= CW'(MEM_LAT - 1);
        end
        RWAIT: begin
          // Read data is consumed on the final wait edge.
          if (cnt == '0) begin
            if (store_q) begin
              state     <= WR;
              mem_en    <= 1'b1;
              mem_rw    <= 1'b1;
              mem_wdata <= merge_word(mem_rdata, size_q, lane_q, wdata_q);
            end else begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= extract_word(mem_rdata, size_q, lane_q, uns_q);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= '0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: two instances (read latency 1 and 3) against a transaction-level model.
module tb_lsu_ctrl;

  localparam int unsigned LAT0  = 1;
  localparam int unsigned LAT1  = 3;
  localparam int unsigned DEPTH = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_store    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic        mem_en       [2];
  logic        mem_rw       [2];
  logic [31:0] mem_rdata    [2];
  logic        resp_valid   [2];
  logic [31:0] resp_data    [2];
  logic        resp_err     [2];

  logic [31:0] dmem [2][256];
  logic [31:0] rmem [2][256];

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.MEM_LAT(LAT0), .DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_en(mem_en[0]), .mem_rw(mem_rw[0]),
    .mem_rdata(mem_rdata[0]), .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
    .resp_err(resp_err[0]));

  lsu_ctrl #(.MEM_LAT(LAT1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_en(mem_en[1]), .mem_rw(mem_rw[1]),
    .mem_rdata(mem_rdata[1]), .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
    .resp_err(resp_err[1]));

  // datamem stand-in: read data appears LT cycles after the strobe, junk otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int unsigned LT = (g == 0) ? LAT0 : LAT1;
    int          pend = 0;
    logic        act  = 1'b0;
    logic [31:0] word = '0;
    logic [31:0] junk = '0;
    always @(posedge clk) begin
      if (mem_en[g] && mem_rw[g]) dmem[g][mem_addr[g][7:0]] = mem_wdata[g];
      if (mem_en[g] && !mem_rw[g]) begin
        act  <= 1'b1;
        pend <= int'(LT) - 1;
        word <= dmem[g][mem_addr[g][7:0]];
      end else if (act) begin
        if (pend == 0) act <= 1'b0;
        else pend <= pend - 1;
      end
      junk <= $urandom;
    end
    assign mem_rdata[g] = (act && pend == 0) ? word : junk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           ({2'b00, a[31:2]} >= DEPTH);
  endfunction

  function automatic int lane_shift(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                           input bit uns, input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    v = w >> lane_shift(sz, a);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_model(input logic [31:0] old, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    if (sz == 2'd2) return wd;
    mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (old & ~(mask << lane_shift(sz, a))) | ((wd & mask) << lane_shift(sz, a));
  endfunction

  // Issue one request and check every cycle until the controller is idle again.
  task automatic run_req(input int d, input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                         output logic [31:0] got_data, output logic got_err,
                         output logic [31:0] got_wdata);
    int          lt, lat, rd_cyc, wr_cyc;
    bit          err;
    logic [7:0]  wa;
    logic [31:0] old, exp_data, exp_wr;
    string       tag;
    lt       = (d == 0) ? int'(LAT0) : int'(LAT1);
    err      = is_err(sz, addr);
    wa       = addr[9:2];
    old      = rmem[d][wa];
    exp_data = (err || st) ? 32'd0 : ld_model(old, sz, uns, addr);
    exp_wr   = st ? st_model(old, sz, addr, wd) : 32'd0;
    if (err)              lat = 1;
    else if (!st)         lat = 2 + lt;
    else if (sz == 2'd2)  lat = 2;
    else                  lat = 3 + lt;
    rd_cyc = (!err && !(st && sz == 2'd2)) ? 1 : 0;
    wr_cyc = (err || !st) ? 0 : ((sz == 2'd2) ? 1 : 2 + lt);
    tag = $sformatf("dut%0d %s sz%0d a%08h", d, st ? "st" : "ld", sz, addr);
    got_data = '0; got_err = 1'b0; got_wdata = '0;

    req_store[d] = st; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
    chk({tag, " ready_idle"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid[d] = hold;
        req_store[d] = 1'($urandom); req_size[d] = 2'($urandom);
        req_unsigned[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
      end
      if (k == lat) req_valid[d] = 1'b0;
      chk($sformatf("%s c%0d ready_busy", tag, k), 32'(req_ready[d]), 32'd0);
      chk($sformatf("%s c%0d mem_en", tag, k), 32'(mem_en[d]),
          32'((k == rd_cyc) || (k == wr_cyc)));
      if (k == rd_cyc || k == wr_cyc)
        chk($sformatf("%s c%0d mem_rw", tag, k), 32'(mem_rw[d]), 32'(k == wr_cyc));
      chk($sformatf("%s c%0d resp_valid", tag, k), 32'(resp_valid[d]), 32'(k == lat));
      if (!err)
        chk($sformatf("%s c%0d mem_addr", tag, k), mem_addr[d], {2'b00, addr[31:2]});
      if (k == wr_cyc) begin
        chk($sformatf("%s c%0d mem_wdata", tag, k), mem_wdata[d], exp_wr);
        got_wdata = mem_wdata[d];
      end
      if (k == lat) begin
        chk({tag, " resp_err"}, 32'(resp_err[d]), 32'(err));
        chk({tag, " resp_data"}, resp_data[d], exp_data);
        got_data = resp_data[d];
        got_err  = resp_err[d];
      end
    end
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(req_ready[d]), 32'd1);
    chk({tag, " resp_valid_after"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, " mem_en_after"}, 32'(mem_en[d]), 32'd0);
    if (st && !err) rmem[d][wa] = exp_wr;
  endtask

  task automatic chk_reset_outputs(input int d, input string nm);
    chk({nm, " mem_addr"},   mem_addr[d], 32'd0);
    chk({nm, " mem_wdata"},  mem_wdata[d], 32'd0);
    chk({nm, " mem_en"},     32'(mem_en[d]), 32'd0);
    chk({nm, " mem_rw"},     32'(mem_rw[d]), 32'd0);
    chk({nm, " resp_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({nm, " resp_data"},  resp_data[d], 32'd0);
    chk({nm, " resp_err"},   32'(resp_err[d]), 32'd0);
    chk({nm, " req_ready"},  32'(req_ready[d]), 32'd1);
  endtask

  logic [31:0] gd, gw, a;
  logic        ge;
  logic [1:0]  sz;
  int          r;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_store[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      for (int i = 0; i < 256; i++) begin
        dmem[d][i] = $urandom;
        rmem[d][i] = dmem[d][i];
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_reset_outputs(d, $sformatf("dut%0d reset", d));
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_reset_outputs(d, $sformatf("dut%0d post_reset", d));

    // Word store then load at 0x8.
    run_req(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0, gd, ge, gw);
    chk("lit sw wdata", gw, 32'hDEADBEEF);
    chk("lit sw mem", dmem[0][2], 32'hDEADBEEF);
    run_req(0, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, gd, ge, gw);
    chk("lit lw data", gd, 32'hDEADBEEF);

    // Byte read-modify-write.
    run_req(0, 1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, 1'b0, gd, ge, gw);
    run_req(0, 1'b1, 2'd0, 1'b0, 32'hA, 32'hFFFF_FFAA, 1'b0, gd, ge, gw);
    chk("lit sb merged", gw, 32'h11AA3344);
    chk("lit sb mem", dmem[0][2], 32'h11AA3344);

    // Sign and zero extension.
    run_req(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h8000FF80, 1'b0, gd, ge, gw);
    run_req(0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, gd, ge, gw);
    chk("lit lb", gd, 32'hFFFFFF80);
    run_req(0, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 1'b0, gd, ge, gw);
    chk("lit lbu", gd, 32'h00000080);
    run_req(0, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 1'b0, gd, ge, gw);
    chk("lit lh", gd, 32'hFFFF8000);
    run_req(0, 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 1'b0, gd, ge, gw);
    chk("lit lhu", gd, 32'h00008000);

    // Error cases.
    run_req(0, 1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1'b0, gd, ge, gw);
    chk("lit err half err", 32'(ge), 32'd1);
    chk("lit err half data", gd, 32'd0);
    run_req(0, 1'b1, 2'd2, 1'b0, 32'h6, 32'h12345678, 1'b0, gd, ge, gw);
    chk("lit err word err", 32'(ge), 32'd1);
    run_req(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0, gd, ge, gw);
    chk("lit err size err", 32'(ge), 32'd1);
    run_req(0, 1'b0, 2'd2, 1'b0, 32'h40000, 32'h0, 1'b0, gd, ge, gw);
    chk("lit err range err", 32'(ge), 32'd1);
    chk("lit err range data", gd, 32'd0);

    // Longer read latency, with valid held while busy.
    run_req(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE1234, 1'b1, gd, ge, gw);
    run_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, gd, ge, gw);
    chk("lit lat3 lw", gd, 32'hCAFE1234);
    run_req(1, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 1'b1, gd, ge, gw);
    chk("lit lat3 sh merged", gw, 32'hBEEF1234);

    // Reset during the wait phase of a byte store drops it.
    req_store[1] = 1'b1; req_size[1] = 2'd0; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h15; req_wdata[1] = 32'h5A; req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rstmid rd strobe", 32'(mem_en[1]), 32'd1);
    @(negedge clk);
    chk("rstmid rwait en", 32'(mem_en[1]), 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk_reset_outputs(1, "rstmid");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid idle%0d mem_en", k), 32'(mem_en[1]), 32'd0);
      chk($sformatf("rstmid idle%0d resp_valid", k), 32'(resp_valid[1]), 32'd0);
    end
    chk("rstmid mem unchanged", dmem[1][5], rmem[1][5]);
    run_req(1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, gd, ge, gw);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        a = (r == 0) ? $urandom : 32'($urandom_range(0, 1023));
        r = $urandom_range(0, 9);
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        run_req(d, 1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom), gd, ge, gw);
      end
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        chk($sformatf("dut%0d final mem[%0d]", d, i), dmem[d][i], rmem[d][i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
